// File: rtl/pgm_sched.sv
// Run controller for the packet generator: decodes config words on the cin/cout chain,
// holds the run registers and paces generate requests with a programmable gap.
module pgm_sched #(
    parameter logic [7:0] MODULE_ID = 8'd70,
    parameter int         CNT_W     = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [133:0] cin_sched_data,
    input  logic         cin_sched_data_wr,
    output logic         cout_sched_ready,
    output logic [133:0] cout_sched_data,
    output logic         cout_sched_data_wr,
    input  logic         cin_sched_ready,
    output logic         out_sched_gen_req,
    input  logic         in_sched_gen_done,
    input  logic         in_sched_alf,
    output logic         out_sched_sent_start_flag,
    output logic         out_sched_sent_finish_flag,
    output logic         out_sched_busy
);

    localparam logic [7:0] ADDR_CTRL    = 8'd61;
    localparam logic [7:0] ADDR_GAP     = 8'd62;
    localparam logic [7:0] ADDR_PKT_NUM = 8'd63;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_GAP   = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] masked_merge(
        input logic [CNT_W-1:0] old_val,
        input logic [CNT_W-1:0] new_val,
        input logic [CNT_W-1:0] mask
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    state_t             state_r;
    state_t             state_nx_s;
    logic [CNT_W-1:0]   gap_r;
    logic [CNT_W-1:0]   pkt_num_r;
    logic [CNT_W-1:0]   pkt_run_r;
    logic [CNT_W-1:0]   sent_cnt_r;
    logic [CNT_W-1:0]   gap_cnt_r;
    logic               stop_r;

    logic               cfg_wr_s;
    logic [7:0]         addr_s;
    logic [CNT_W-1:0]   mask_s;
    logic [CNT_W-1:0]   wdata_s;
    logic               start_wr_s;
    logic               sent_inc_s;
    logic               gap_load_s;
    logic [CNT_W:0]     sent_p1_s;

    assign addr_s    = cin_sched_data[103:96];
    assign mask_s    = CNT_W'(cin_sched_data[63:32]);
    assign wdata_s   = CNT_W'(cin_sched_data[31:0]);
    assign cfg_wr_s  = cin_sched_data_wr
                       && (cin_sched_data[133:132] == 2'b01)
                       && cin_sched_data[127]
                       && (cin_sched_data[126:124] == 3'b010)
                       && (cin_sched_data[111:104] == MODULE_ID);
    // start is a strobe: it never lands in a register, it only kicks the FSM
    assign start_wr_s = cfg_wr_s && (addr_s == ADDR_CTRL) && mask_s[0] && wdata_s[0];
    assign sent_p1_s  = {1'b0, sent_cnt_r} + {{CNT_W{1'b0}}, 1'b1};

    // Next-state logic for the run FSM
    always_comb begin
        state_nx_s = state_r;
        sent_inc_s = 1'b0;
        gap_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_wr_s) begin
                    state_nx_s = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (pkt_run_r == {CNT_W{1'b0}}) begin
                    state_nx_s = ST_FIN;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!in_sched_alf) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (in_sched_gen_done) begin
                    sent_inc_s = 1'b1;
                    if ((sent_p1_s == {1'b0, pkt_run_r}) || stop_r) begin
                        state_nx_s = ST_FIN;
                    end else if (gap_r != {CNT_W{1'b0}}) begin
                        state_nx_s = ST_GAP;
                        gap_load_s = 1'b1;
                    end else begin
                        state_nx_s = ST_ISSUE;
                    end
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_GAP: begin
                if (stop_r) begin
                    state_nx_s = ST_FIN;
                end else if (gap_cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
                    state_nx_s = ST_ISSUE;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            ST_FIN: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, registered outputs, config registers and run counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r                    <= ST_IDLE;
            out_sched_gen_req          <= 1'b0;
            out_sched_sent_start_flag  <= 1'b0;
            out_sched_sent_finish_flag <= 1'b0;
            out_sched_busy             <= 1'b0;
            cout_sched_data            <= 134'd0;
            cout_sched_data_wr         <= 1'b0;
            cout_sched_ready           <= 1'b0;
            gap_r                      <= {CNT_W{1'b0}};
            pkt_num_r                  <= {CNT_W{1'b0}};
            pkt_run_r                  <= {CNT_W{1'b0}};
            sent_cnt_r                 <= {CNT_W{1'b0}};
            gap_cnt_r                  <= {CNT_W{1'b0}};
            stop_r                     <= 1'b0;
        end else begin
            state_r                    <= state_nx_s;
            out_sched_gen_req          <= (state_r == ST_ISSUE) && (state_nx_s == ST_WAIT);
            out_sched_sent_start_flag  <= (state_nx_s == ST_START);
            out_sched_sent_finish_flag <= (state_nx_s == ST_FIN);
            out_sched_busy             <= (state_nx_s != ST_IDLE);
            cout_sched_data            <= cin_sched_data;
            cout_sched_data_wr         <= cin_sched_data_wr;
            cout_sched_ready           <= cin_sched_ready;

            if (cfg_wr_s && (addr_s == ADDR_GAP)) begin
                gap_r <= masked_merge(gap_r, wdata_s, mask_s);
            end
            if (cfg_wr_s && (addr_s == ADDR_PKT_NUM)) begin
                pkt_num_r <= masked_merge(pkt_num_r, wdata_s, mask_s);
            end
            // FIN retires the stop request so the next run starts clean
            if (state_r == ST_FIN) begin
                stop_r <= 1'b0;
            end else if (cfg_wr_s && (addr_s == ADDR_CTRL) && mask_s[1]) begin
                stop_r <= wdata_s[1];
            end

            if ((state_r == ST_IDLE) && (state_nx_s == ST_START)) begin
                pkt_run_r  <= pkt_num_r;
                sent_cnt_r <= {CNT_W{1'b0}};
            end else if (sent_inc_s && (sent_cnt_r != {CNT_W{1'b1}})) begin
                sent_cnt_r <= sent_p1_s[CNT_W-1:0];
            end

            if (gap_load_s) begin
                gap_cnt_r <= gap_r;
            end else if ((state_r == ST_GAP) && (gap_cnt_r != {CNT_W{1'b0}})) begin
                gap_cnt_r <= gap_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_pgm_sched.sv
// Scoreboard bench for pgm_sched: expected flag/request sequence and forwarded words are
// queued as stimulus is driven and popped as the DUT produces them.
module tb_pgm_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [133:0] cin_sched_data;
    logic         cin_sched_data_wr;
    logic         cout_sched_ready;
    logic [133:0] cout_sched_data;
    logic         cout_sched_data_wr;
    logic         cin_sched_ready;
    logic         out_sched_gen_req;
    logic         in_sched_gen_done;
    logic         in_sched_alf;
    logic         out_sched_sent_start_flag;
    logic         out_sched_sent_finish_flag;
    logic         out_sched_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_lat = 2;
    logic [7:0] hist = 8'd0;

    int           exp_q[$];
    logic [133:0] fwd_q[$];
    int           fwd_t[$];
    int           req_cyc[$];
    int           start_cyc = 0;
    int           fin_cyc = 0;
    int           fin_cnt = 0;

    pgm_sched dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .cin_sched_data             (cin_sched_data),
        .cin_sched_data_wr          (cin_sched_data_wr),
        .cout_sched_ready           (cout_sched_ready),
        .cout_sched_data            (cout_sched_data),
        .cout_sched_data_wr         (cout_sched_data_wr),
        .cin_sched_ready            (cin_sched_ready),
        .out_sched_gen_req          (out_sched_gen_req),
        .in_sched_gen_done          (in_sched_gen_done),
        .in_sched_alf               (in_sched_alf),
        .out_sched_sent_start_flag  (out_sched_sent_start_flag),
        .out_sched_sent_finish_flag (out_sched_sent_finish_flag),
        .out_sched_busy             (out_sched_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [133:0] got, input logic [133:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // pgm model: done arrives done_lat cycles after each request
    always @(negedge clk) begin
        hist = {hist[6:0], out_sched_gen_req};
        in_sched_gen_done = hist[done_lat];
    end

    task automatic sb_event(input int code);
        if (exp_q.size() == 0) check_val("unexpected_event", 134'(code), 134'd0);
        else check_val("event_order", 134'(code), 134'(exp_q.pop_front()));
    endtask

    // Output monitor
    always @(negedge clk) begin
        if (out_sched_sent_start_flag) begin
            start_cyc = cyc;
            sb_event(1);
        end
        if (out_sched_gen_req) begin
            req_cyc.push_back(cyc);
            sb_event(2);
        end
        if (out_sched_sent_finish_flag) begin
            fin_cyc = cyc;
            fin_cnt++;
            sb_event(3);
        end
        if (cout_sched_data_wr) begin
            if (fwd_q.size() == 0) check_val("fwd_unexpected", 134'd1, 134'd0);
            else begin
                check_val("fwd_data", cout_sched_data, fwd_q.pop_front());
                check_val("fwd_latency", 134'(cyc - fwd_t.pop_front()), 134'd1);
            end
        end
    end

    task automatic send_word(input logic [133:0] w);
        @(negedge clk);
        cin_sched_data = w;
        cin_sched_data_wr = 1'b1;
        fwd_q.push_back(w);
        fwd_t.push_back(cyc);
        @(negedge clk);
        cin_sched_data_wr = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [31:0] mask, input logic [31:0] data,
                          input logic [7:0] id = 8'd70, input logic [1:0] kind = 2'b01);
        logic [133:0] w;
        w = 134'd0;
        w[133:132] = kind;
        w[127] = 1'b1;
        w[126:124] = 3'b010;
        w[111:104] = id;
        w[103:96] = addr;
        w[63:32] = mask;
        w[31:0] = data;
        send_word(w);
    endtask

    task automatic start_run(input int nreq);
        req_cyc.delete();
        exp_q.push_back(1);
        for (int i = 0; i < nreq; i++) exp_q.push_back(2);
        exp_q.push_back(3);
        wr_reg(8'd61, 32'h0000_0001, 32'h0000_0001);
    endtask

    task automatic wait_fin(input string tag, input int nreq, input int budget);
        int f0;
        int n;
        f0 = fin_cnt;
        n = 0;
        while (fin_cnt == f0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val({tag, "_finished"}, 134'(fin_cnt - f0), 134'd1);
        @(negedge clk);
        #1;
        check_val({tag, "_events_left"}, 134'(exp_q.size()), 134'd0);
        check_val({tag, "_req_count"}, 134'(req_cyc.size()), 134'(nreq));
        check_val({tag, "_idle"}, 134'(out_sched_busy), 134'd0);
    endtask

    task automatic wait_reqs(input int n);
        for (int i = 0; i < 2000 && req_cyc.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        check_val("req_seen", 134'(req_cyc.size() >= n), 134'd1);
    endtask

    initial begin
        int f0;
        rst_n = 1'b0;
        cin_sched_data = 134'd0;
        cin_sched_data_wr = 1'b0;
        cin_sched_ready = 1'b0;
        in_sched_alf = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_outs", {cout_sched_data, out_sched_gen_req, out_sched_sent_start_flag,
                  out_sched_sent_finish_flag, out_sched_busy, cout_sched_data_wr, cout_sched_ready},
                  134'd0);
        rst_n = 1'b1;

        // ready is a registered copy
        cin_sched_ready = 1'b1;
        @(negedge clk);
        #1;
        check_val("ready_hi", 134'(cout_sched_ready), 134'd1);
        cin_sched_ready = 1'b0;
        @(negedge clk);
        #1;
        check_val("ready_lo", 134'(cout_sched_ready), 134'd0);
        cin_sched_ready = 1'b1;

        // 1: foreign id, body word and read op never touch registers or start a run
        wr_reg(8'd63, 32'hffff_ffff, 32'd1);
        wr_reg(8'd62, 32'hffff_ffff, 32'd0);
        wr_reg(8'd63, 32'hffff_ffff, 32'd9, 8'd71);
        wr_reg(8'd63, 32'hffff_ffff, 32'd9, 8'd70, 2'b11);
        wr_reg(8'd61, 32'hffff_ffff, 32'd1, 8'd71);
        wr_reg(8'd61, 32'hffff_ffff, 32'd1, 8'd70, 2'b10);
        repeat (5) @(negedge clk);
        #1;
        check_val("foreign_no_start", 134'(out_sched_busy), 134'd0);
        start_run(1);
        wait_fin("pkt_num_kept", 1, 100);

        // 2: three packets back to back, done after 2 cycles
        wr_reg(8'd63, 32'hffff_ffff, 32'd3);
        wr_reg(8'd62, 32'hffff_ffff, 32'd0);
        req_cyc.delete();
        exp_q.push_back(1);
        repeat (3) exp_q.push_back(2);
        exp_q.push_back(3);
        wr_reg(8'd61, 32'hffff_ffff, 32'd1);
        wait_fin("run3", 3, 200);
        check_val("run3_first_req", 134'(req_cyc[0] - start_cyc), 134'd2);
        check_val("run3_space01", 134'(req_cyc[1] - req_cyc[0]), 134'd4);
        check_val("run3_space12", 134'(req_cyc[2] - req_cyc[1]), 134'd4);
        check_val("run3_fin", 134'(fin_cyc - req_cyc[2]), 134'd3);

        // 3: masked writes build GAP=0xF5; done latency 3
        wr_reg(8'd62, 32'h0000_000f, 32'h0000_0005);
        wr_reg(8'd62, 32'h0000_00f0, 32'h0000_00f0);
        wr_reg(8'd63, 32'hffff_ffff, 32'd2);
        done_lat = 3;
        start_run(2);
        wait_fin("gap", 2, 1000);
        check_val("gap_spacing", 134'(req_cyc[1] - req_cyc[0]), 134'd250);
        done_lat = 2;

        // 4: almost-full holds ISSUE
        wr_reg(8'd62, 32'hffff_ffff, 32'd0);
        wr_reg(8'd63, 32'hffff_ffff, 32'd1);
        in_sched_alf = 1'b1;
        start_run(1);
        repeat (10) @(negedge clk);
        #1;
        check_val("alf_no_req", 134'(req_cyc.size()), 134'd0);
        in_sched_alf = 1'b0;
        f0 = cyc;
        wait_fin("alf", 1, 100);
        check_val("alf_req_time", 134'(req_cyc[0] - f0), 134'd1);

        // 5a: empty run
        wr_reg(8'd63, 32'hffff_ffff, 32'd0);
        start_run(0);
        wait_fin("zero", 0, 100);
        check_val("zero_fin_next", 134'(fin_cyc - start_cyc), 134'd1);

        // 5b: stop during the second of five packets
        wr_reg(8'd63, 32'hffff_ffff, 32'd5);
        start_run(2);
        wait_reqs(2);
        wr_reg(8'd61, 32'h0000_0002, 32'h0000_0002);
        wait_fin("stop", 2, 200);
        check_val("stop_fin", 134'(fin_cyc - req_cyc[1]), 134'd3);

        // 6: reset while in GAP, then a fresh run
        wr_reg(8'd62, 32'hffff_ffff, 32'd20);
        wr_reg(8'd63, 32'hffff_ffff, 32'd3);
        start_run(3);
        wait_reqs(1);
        repeat (5) @(negedge clk);
        #1;
        check_val("pre_rst_pending", 134'(exp_q.size()), 134'd3);
        exp_q.delete();
        f0 = fin_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_val("midrun_reset_outs", {cout_sched_data, out_sched_gen_req, out_sched_sent_start_flag,
                  out_sched_sent_finish_flag, out_sched_busy, cout_sched_data_wr, cout_sched_ready},
                  134'd0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check_val("post_rst_idle", 134'(out_sched_busy), 134'd0);
        check_val("post_rst_no_fin", 134'(fin_cnt - f0), 134'd0);
        wr_reg(8'd63, 32'hffff_ffff, 32'd2);
        start_run(2);
        wait_fin("after_rst", 2, 200);
        check_val("after_rst_space", 134'(req_cyc[1] - req_cyc[0]), 134'd4);
        check_val("fwd_drained", 134'(fwd_q.size()), 134'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
